// File: rtl/ber_pkg.sv
// Shared definitions for the PRBS bit-error-rate checker.
//   ber_state_e : checker FSM states
//   lfsr_sel_e  : source of the bit shifted into the local LFSR
//   PRBS9_*     : default PRBS9 polynomial mask (x^9+x^5+1) and generator seed
//   clog2       : ceiling log2, used to size the internal counters
package ber_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } ber_state_e;

  typedef enum logic {
    SEL_PRED = 1'b0,
    SEL_RX   = 1'b1
  } lfsr_sel_e;

  localparam logic [8:0] PRBS9_TAPS = 9'h110;
  localparam logic [8:0] PRBS9_SEED = 9'h1AA;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_ber_checker_if.sv
// Bit-stream and status bundle of the BER checker.
//   enable, rx_in, clear          : stream strobe, received bit, statistic clear
//   locked, err_pulse             : lock status, one-cycle error flag
//   bit_count, err_count [CNT_W]  : saturating statistics
// master = stream source / status reader, slave = checker.
interface prbs_ber_checker_if #(
  parameter int CNT_W = 32
);
  logic             enable;
  logic             rx_in;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output enable, rx_in, clear,
    input  locked, err_pulse, bit_count, err_count
  );

  modport slave (
    input  enable, rx_in, clear,
    output locked, err_pulse, bit_count, err_count
  );
endinterface

// File: rtl/ber_lfsr.sv
// Local LFSR of the BER checker. s[0] holds the most recent bit.
//   clk, rst  : clock, synchronous active-high reset (state to zero)
//   shift     : advance one bit
//   load_sel  : SEL_RX shifts in din, SEL_PRED shifts in the prediction
//   din       : received bit
//   pred      : predicted next bit, parity of state under TAPS
//   zero      : state is all-zero (a stuck LFSR that would predict zeros forever)
module ber_lfsr
  import ber_pkg::*;
#(
  parameter int           N    = 9,
  parameter logic [N-1:0] TAPS = PRBS9_TAPS
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      shift,
  input  lfsr_sel_e load_sel,
  input  logic      din,
  output logic      pred,
  output logic      zero
);

  logic [N-1:0] s_q;
  logic [N-1:0] s_d;
  logic         fb;

  assign pred = ^(s_q & TAPS);
  assign zero = (s_q == '0);

  always_comb begin
    fb  = (load_sel == SEL_RX) ? din : pred;
    s_d = s_q;
    if (shift) begin
      s_d = {s_q[N-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/prbs_ber_checker.sv
// Self-synchronising PRBS bit-error-rate checker.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of prbs_ber_checker_if (stream in, status/statistics out)
// All outputs are registered; one bit per clock when enable is held high.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_LOAD   | filling the LFSR with PRBS_LEN received bits
// ST_VERIFY | free-running prediction, needs VERIFY_LEN correct bits in a row
// ST_LOCKED | aligned; counting bits/errors, windowed lock-loss monitor
module prbs_ber_checker
  import ber_pkg::*;
#(
  parameter int                  PRBS_LEN   = 9,
  parameter logic [PRBS_LEN-1:0] TAPS       = PRBS9_TAPS,
  parameter int                  VERIFY_LEN = 18,
  parameter int                  WIN        = 64,
  parameter int                  LOSS_THR   = 8,
  parameter int                  CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  prbs_ber_checker_if.slave  bus
);

  localparam int FILL_W = clog2(PRBS_LEN + 1);
  localparam int VER_W  = clog2(VERIFY_LEN + 1);
  localparam int WIN_W  = clog2(WIN + 1);
  localparam int WERR_W = clog2(LOSS_THR + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ber_state_e        state_q, state_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [VER_W-1:0]  ver_cnt_q, ver_cnt_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0] win_err_q, win_err_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  logic      shift;
  lfsr_sel_e load_sel;
  logic      pred;
  logic      zero;
  logic      mismatch;
  logic      count_bit;

  ber_lfsr #(
    .N    (PRBS_LEN),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .shift    (shift),
    .load_sel (load_sel),
    .din      (bus.rx_in),
    .pred     (pred),
    .zero     (zero)
  );

  assign mismatch = bus.rx_in ^ pred;

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    ver_cnt_d   = ver_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    shift       = 1'b0;
    load_sel    = SEL_PRED;
    count_bit   = 1'b0;

    if (bus.enable) begin
      shift = 1'b1;
      unique case (state_q)
        ST_LOAD: begin
          load_sel = SEL_RX;
          if (fill_cnt_q == FILL_W'(PRBS_LEN - 1)) begin
            state_d    = ST_VERIFY;
            fill_cnt_d = '0;
            ver_cnt_d  = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end

        ST_VERIFY: begin
          if (mismatch || zero) begin
            state_d    = ST_LOAD;
            fill_cnt_d = '0;
          end else if (ver_cnt_q == VER_W'(VERIFY_LEN - 1)) begin
            state_d   = ST_LOCKED;
            locked_d  = 1'b1;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            ver_cnt_d = ver_cnt_q + 1'b1;
          end
        end

        ST_LOCKED: begin
          count_bit   = 1'b1;
          err_pulse_d = mismatch;
          // Loss check counts the current bit; it takes priority over the
          // window wrap so an error landing on the last window bit still counts.
          if (mismatch && (win_err_q == WERR_W'(LOSS_THR - 1))) begin
            state_d    = ST_LOAD;
            locked_d   = 1'b0;
            fill_cnt_d = '0;
          end else if (win_cnt_q == WIN_W'(WIN - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_q + WERR_W'(mismatch);
          end
        end

        default: begin
          state_d    = ST_LOAD;
          fill_cnt_d = '0;
        end
      endcase
    end
  end

  // Statistics freeze together once bit_count saturates, so the error ratio
  // stays meaningful until software clears them.
  always_comb begin
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;
    if (bus.clear) begin
      bit_count_d = '0;
      err_count_d = '0;
    end else if (count_bit && (bit_count_q != CNT_MAX)) begin
      bit_count_d = bit_count_q + 1'b1;
      if (mismatch && (err_count_q != CNT_MAX)) begin
        err_count_d = err_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      fill_cnt_q  <= '0;
      ver_cnt_q   <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      ver_cnt_q   <= ver_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.bit_count = bit_count_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Testbench for prbs_ber_checker. Two instances: dut_a with default
// parameters, dut_b with CNT_W=4 and LOSS_THR=WIN=64 for saturation.
// Stimulus pushes hand-derived expectations tagged with the enabled-bit
// index; a monitor counts enabled bits per DUT and compares when the tag matches.
module tb_prbs_ber_checker;
  import ber_pkg::*;

  typedef struct {
    int   idx;
    logic lk;
    logic pl;
    int   bc;
    int   ec;
  } exp_t;

  logic clk;
  logic rst;

  prbs_ber_checker_if #(.CNT_W(32)) bus_a ();
  prbs_ber_checker_if #(.CNT_W(4))  bus_b ();

  prbs_ber_checker #(
    .PRBS_LEN(9), .TAPS(9'h110), .VERIFY_LEN(18), .WIN(64), .LOSS_THR(8), .CNT_W(32)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  prbs_ber_checker #(
    .PRBS_LEN(9), .TAPS(9'h110), .VERIFY_LEN(18), .WIN(64), .LOSS_THR(64), .CNT_W(4)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int sent[2];
  int seen[2];
  exp_t q_a[$];
  exp_t q_b[$];
  logic [8:0] gen_a;
  logic [8:0] gen_b;

  logic rst_seen  = 1'b0;
  logic en_seen_a = 1'b0;
  logic en_seen_b = 1'b0;

  always @(posedge clk) begin
    rst_seen  <= rst;
    en_seen_a <= bus_a.enable;
    en_seen_b <= bus_b.enable;
  end

  task automatic cmp(input string name, input int d, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d bit=%0d t=%0t: got %0d, expected %0d",
               name, d, seen[d], $time, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic en_s, input logic lk, input logic pl,
                     input logic [63:0] bc, input logic [63:0] ec);
    exp_t e;
    bit   have;
    if (rst_seen) begin
      cmp("rst_locked", d, {63'd0, lk}, 64'd0);
      cmp("rst_err_pulse", d, {63'd0, pl}, 64'd0);
      cmp("rst_bit_count", d, bc, 64'd0);
      cmp("rst_err_count", d, ec, 64'd0);
    end else if (en_s) begin
      seen[d]++;
      have = 1'b0;
      if (d == 0 && q_a.size() > 0 && q_a[0].idx == seen[d]) begin
        e = q_a.pop_front();
        have = 1'b1;
      end
      if (d == 1 && q_b.size() > 0 && q_b[0].idx == seen[d]) begin
        e = q_b.pop_front();
        have = 1'b1;
      end
      if (have) begin
        cmp("locked", d, {63'd0, lk}, {63'd0, e.lk});
        cmp("err_pulse", d, {63'd0, pl}, {63'd0, e.pl});
        cmp("bit_count", d, bc, 64'(e.bc));
        cmp("err_count", d, ec, 64'(e.ec));
      end
    end else begin
      cmp("idle_err_pulse", d, {63'd0, pl}, 64'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, en_seen_a, bus_a.locked, bus_a.err_pulse, 64'(bus_a.bit_count), 64'(bus_a.err_count));
    mon(1, en_seen_b, bus_b.locked, bus_b.err_pulse, 64'(bus_b.bit_count), 64'(bus_b.err_count));
  end

  // Reference PRBS generator: p = s[8]^s[4], s <= {s[7:0], p}, output p.
  function automatic logic gen_next(input int d);
    logic p;
    if (d == 0) begin
      p = ^(gen_a & 9'h110);
      gen_a = {gen_a[7:0], p};
    end else begin
      p = ^(gen_b & 9'h110);
      gen_b = {gen_b[7:0], p};
    end
    return p;
  endfunction

  // mode: 0 clean PRBS, 1 inverted PRBS, 2 constant 0, 3 constant 1.
  task automatic send(input int d, input int mode, input bit clr, input int gap,
                      input bit chk, input bit e_lk, input bit e_pl,
                      input int e_bc, input int e_ec);
    logic b;
    exp_t e;
    case (mode)
      0:       b = gen_next(d);
      1:       b = ~gen_next(d);
      2:       b = 1'b0;
      default: b = 1'b1;
    endcase
    sent[d]++;
    if (chk) begin
      e.idx = sent[d];
      e.lk  = e_lk;
      e.pl  = e_pl;
      e.bc  = e_bc;
      e.ec  = e_ec;
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
    if (d == 0) begin
      bus_a.enable = 1'b1; bus_a.rx_in = b; bus_a.clear = clr;
    end else begin
      bus_b.enable = 1'b1; bus_b.rx_in = b; bus_b.clear = clr;
    end
    @(negedge clk);
    if (d == 0) begin
      bus_a.enable = 1'b0; bus_a.clear = 1'b0;
    end else begin
      bus_b.enable = 1'b0; bus_b.clear = 1'b0;
    end
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    sent[0] = 0; sent[1] = 0;
    seen[0] = 0; seen[1] = 0;
    gen_a = PRBS9_SEED;
    gen_b = PRBS9_SEED;
    bus_a.enable = 1'b0; bus_a.rx_in = 1'b0; bus_a.clear = 1'b0;
    bus_b.enable = 1'b0; bus_b.rx_in = 1'b0; bus_b.clear = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Acquisition with enable every 4th clock, then 100 clean counted bits.
    for (int i = 1; i <= 127; i++)
      send(0, 0, 1'b0, 3, (i == 26 || i == 27 || i == 28 || i == 127),
           (i >= 27), 1'b0, (i >= 28) ? i - 27 : 0, 0);

    // Single inverted bit while locked, back-to-back strobes from here on.
    send(0, 1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 101, 1);
    send(0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 102, 1);
    for (int i = 130; i <= 155; i++)
      send(0, 0, 1'b0, 0, (i == 155), 1'b1, 1'b0, i - 27, 1);

    // Clear on an idle cycle.
    bus_a.clear = 1'b1;
    @(negedge clk);
    bus_a.clear = 1'b0;

    // Eight errors in the window starting at bit 156: lock drops on the 8th.
    for (int i = 156; i <= 170; i++)
      send(0, (i % 2 == 0) ? 1 : 0, 1'b0, 0,
           (i == 156 || i == 168 || i == 169 || i == 170),
           (i != 170), (i % 2 == 0), i - 155, (i - 156) / 2 + 1);

    // Relock 27 clean bits later; err_count holds at 8.
    for (int i = 171; i <= 198; i++)
      send(0, 0, 1'b0, 0, (i == 196 || i == 197 || i == 198),
           (i >= 197), 1'b0, (i == 198) ? 16 : 15, 8);

    // Clear coincident with a (bad) checked bit, then one further bit.
    send(0, 1, 1'b1, 0, 1'b1, 1'b1, 1'b1, 0, 0);
    send(0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1, 0);

    // Mid-operation reset with enable and clear asserted.
    rst = 1'b1;
    bus_a.enable = 1'b1; bus_a.rx_in = 1'b1; bus_a.clear = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_a.enable = 1'b0; bus_a.clear = 1'b0;

    // Stuck-at streams never lock.
    for (int i = 201; i <= 700; i++)
      send(0, 2, 1'b0, 0, (i == 227 || i == 700), 1'b0, 1'b0, 0, 0);
    for (int i = 701; i <= 1200; i++)
      send(0, 3, 1'b0, 0, (i == 727 || i == 1200), 1'b0, 1'b0, 0, 0);

    // dut_b: lock, then all-error stream; counters freeze at 15, lock lost at
    // the 64th window error.
    for (int i = 1; i <= 27; i++)
      send(1, 0, 1'b0, 0, (i == 27), 1'b1, 1'b0, 0, 0);
    for (int i = 28; i <= 91; i++)
      send(1, 1, 1'b0, 0, (i == 41 || i == 42 || i == 43 || i == 90 || i == 91),
           (i != 91), 1'b1, (i < 42) ? i - 27 : 15, (i < 42) ? i - 27 : 15);

    rst = 1'b1;
    bus_b.enable = 1'b1; bus_b.rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_b.enable = 1'b0;
    repeat (4) @(negedge clk);

    cmp("pending_a", 0, 64'(q_a.size()), 64'd0);
    cmp("pending_b", 1, 64'(q_b.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs_ber_checker.md
# prbs_ber_checker

Bit-error-rate checker for the receive path. It consumes the recovered bit stream (one bit per `enable` strobe, the same symbol-rate strobe that drives `prbs`), self-synchronises a local LFSR to it, and reports lock status and saturating bit and error counts. It generalises the PRBS generator to any LFSR length and tap set, and adds lock acquisition, lock-loss detection and counter clear.

## Interface

- `PRBS_LEN`, 9: LFSR degree N.
- `TAPS`, 9'h110: feedback mask over state bits; default is x^9+x^5+1.
- `VERIFY_LEN`, 18: consecutive correct bits required before `locked`.
- `WIN`, 64: lock-monitor window length in bits (≥2).
- `LOSS_THR`, 8: errors within one window that drop lock (1..WIN).
- `CNT_W`, 32: width of the statistic counters.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  bit strobe; `rx_in` is valid when this is high.
- `rx_in`  in  1  received bit.
- `clear`  in  1  synchronous clear of `bit_count` and `err_count`.
- `locked`  out  1  LFSR is aligned to the stream.
- `err_pulse`  out  1  one-cycle flag for a mismatched bit while locked.
- `bit_count`  out  CNT_W  bits checked while locked.
- `err_count`  out  CNT_W  mismatches while locked.

## Operation

- **LFSR state.** State is s[N-1:0], with s[0] the most recent bit. Prediction p = ^(s & TAPS). A shift is s <= {s[N-2:0], b}.
- **FSM states.**
  - **LOAD**: on each enabled bit, shift in `rx_in` and increment `fill_cnt`. When the N-th bit is shifted, go to VERIFY with `ver_cnt`=0.
  - **VERIFY**: on each enabled bit, compare `rx_in` with p and shift in p (not `rx_in`).
    - Mismatch, or state all-zero: go to LOAD, `fill_cnt`=0.
    - Otherwise increment `ver_cnt`. On the VERIFY_LEN-th correct bit, go to LOCKED and clear the window.
  - **LOCKED**: on each enabled bit, compare, shift in p, and update `bit_count`, `err_count`, `win_cnt` and `win_err`.
    - If `win_err` reaches LOSS_THR (counting the current bit), go to LOAD, `locked`=0, `fill_cnt`=0.
    - Otherwise, on the WIN-th bit of the window, reset `win_cnt` and `win_err` to 0.
- **Statistic counters.**
  - Both saturate at 2^CNT_W-1.
  - Once `bit_count` saturates, both counters freeze until `clear`.
  - The bit that triggers loss of lock is still counted in `bit_count` and `err_count`.
- **Clear.** `clear` affects only the two statistic counters. If `clear` and `enable` are both high, `clear` wins and that bit is not counted. The FSM and window still process it.
- **Idle cycles.** With `enable` low, nothing changes except `clear`. `err_pulse` goes low.

## Timing

- Reset values, after the first `rst` edge: FSM=LOAD, s=0, all internal counters 0, `locked`=0, `err_pulse`=0, `bit_count`=0, `err_count`=0.
- `rst` mid-operation has the same effect, regardless of `enable` or `clear`.
- All outputs are registered.
- `err_pulse` is high for exactly the cycle following the edge that sampled the bad bit.
- `locked` rises after the edge that samples enabled bit N+VERIFY_LEN of a clean stream (27 with defaults). It falls after the edge that samples the LOSS_THR-th window error.
- Counter updates are visible one cycle after the sampling edge.
- Throughput is one bit per clock. `enable` may be high continuously.

## Structure

- Shared package `ber_pkg`:
  - FSM state enum (LOAD, VERIFY, LOCKED).
  - `PRBS9_TAPS`=9'h110 and `PRBS9_SEED`=9'h1AA constants.
  - A `clog2` helper for the `fill_cnt`, `ver_cnt`, `win_cnt` and `win_err` widths.
- Sub-module `ber_lfsr`: holds s. Inputs are `shift`, `load_sel` (received vs predicted) and `din`. Outputs are `pred` and `zero`. The top level owns the FSM and counters.

## Test plan

1. Reset, then PRBS9 seed 9'h1AA from `prbs`, with `enable` every 4th clock: `locked`=1 after the 27th enabled bit. After a further 100 bits, `bit_count`=100 and `err_count`=0.
2. After lock, invert one bit: `err_pulse` is high for one cycle, `err_count`=1 and `locked` stays 1.
3. After lock, invert 8 bits within 64: `locked` drops after the 8th error, with `err_count`=8. It relocks 27 clean bits later and `err_count` holds at 8.
4. `rx_in` held at 0 (or 1) for 500 enabled bits: `locked` never asserts and both counters stay 0.
5. `clear` coincident with a checked bit: next cycle both counters are 0. One further bit gives `bit_count`=1.
6. With CNT_W=4 and an all-error stream forced after lock (LOSS_THR=WIN=64): `bit_count` and `err_count` freeze at 15. Asserting `rst` then zeroes all outputs one cycle later.
